skid_fifo: RTL and testbench
============================

SKID_FIFO -- requirements
Module: skid_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1, giving the payload width in bits.
REQ-002 SHALL have parameter TYPE, default logic [DATA_WIDTH-1:0], giving the payload type; it overrides DATA_WIDTH when supplied.
REQ-003 SHALL have parameter DEPTH, default 2, giving the number of storage entries; legal range is DEPTH >= 1 and need not be a power of two.
REQ-004 SHALL have parameter FALL_THROUGH, default 0; when 1, an empty buffer passes w_data to r_data in the same cycle.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port flush, input, 1 bit: synchronous discard of all stored entries.
REQ-008 SHALL have ports w_valid (input, 1), w_ready (output, 1) and w_data (input, TYPE) forming the write handshake.
REQ-009 SHALL have ports r_valid (output, 1), r_ready (input, 1) and r_data (output, TYPE) forming the read handshake.
REQ-010 SHALL have port count, output, $clog2(DEPTH+1) bits: the number of stored entries.
REQ-011 SHALL have ports full and empty, outputs, 1 bit each: count==DEPTH and count==0 respectively.

Function
REQ-012 SHALL store entries in a DEPTH-entry circular buffer with read and write pointers that wrap from DEPTH-1 to 0.
REQ-013 SHALL define a write transfer as w_valid && w_ready and a read transfer as r_valid && r_ready, both sampled at the rising edge.
REQ-014 SHALL drive w_ready = !full && !flush, so w_ready depends only on registered state and flush, never on r_ready.
REQ-015 SHALL refuse writes when full, even if a read occurs in the same cycle (no combinational r_ready-to-w_ready path).
REQ-016 SHALL drive r_valid = !empty && !flush when FALL_THROUGH=0; r_data is then mem[rd_ptr], a register-only path.
REQ-017 SHALL drive r_valid = (!empty || w_valid) && !flush when FALL_THROUGH=1; r_data = empty ? w_data : mem[rd_ptr].
REQ-018 SHALL, with FALL_THROUGH=1, empty buffer, w_valid=1 and r_ready=1, pass the word through without storing it; count stays 0 and pointers hold.
REQ-019 SHALL, with FALL_THROUGH=1, empty buffer, w_valid=1 and r_ready=0, store the word; count becomes 1.
REQ-020 SHALL make latency from write to r_valid exactly 1 cycle when FALL_THROUGH=0, and 0 cycles when FALL_THROUGH=1 and empty.
REQ-021 SHALL leave count unchanged on a simultaneous write and read when not full; both pointers advance by one.
REQ-022 SHALL increment count on a write-only cycle, decrement it on a read-only cycle, and keep it within 0..DEPTH at all times.
REQ-023 SHALL deliver words in write order with no loss or duplication; DEPTH consecutive writes with no reads fill the buffer.
REQ-024 SHALL, on flush=1, zero count and both pointers at the next edge, ignore w_valid and r_ready in that cycle, and complete no transfer.
REQ-025 SHALL give flush priority over any simultaneous write or read.
REQ-026 SHALL derive full and empty from count; they are never asserted together.

Reset
REQ-027 SHALL, while rst=1, asynchronously force count=0 and rd_ptr=wr_ptr=0, giving empty=1, full=0, w_ready=1 and r_valid=0 (r_valid=w_valid when FALL_THROUGH=1).
REQ-028 SHALL leave storage contents and r_data unreset; r_data is undefined while r_valid=0.
REQ-029 SHALL discard all in-flight entries on reset mid-operation; the first post-reset read returns the first post-reset write.

Verification
REQ-030 SHALL test DEPTH=3, FALL_THROUGH=0: write 0xA,0xB,0xC with r_ready=0 -> full=1, w_ready=0, count=3; then set r_ready=1 -> reads 0xA,0xB,0xC on consecutive cycles, then empty=1.
REQ-031 SHALL test DEPTH=2, continuous w_valid and r_ready with an incrementing payload 0..9 -> one word per cycle after 1 cycle latency, in order, and count never exceeds 1.
REQ-032 SHALL test DEPTH=1, FALL_THROUGH=1, empty, w_valid=1, w_data=0x5, r_ready=1 -> r_valid=1 and r_data=0x5 in the same cycle, count stays 0.
REQ-033 SHALL test DEPTH=4 full (count=4), w_valid=1 and r_ready=1 -> read completes, write refused, count=3 next cycle.
REQ-034 SHALL test flush at count=2 with w_valid=1 -> next cycle count=0, empty=1, and the flushed-cycle word is never read.
REQ-035 SHALL test rst asserted mid-stream at count=2, asynchronously between clock edges -> count=0 and r_valid=0 immediately; after release, write 0x7 is read first.

Source files
------------

// File: rtl/skid_fifo.sv
// Circular-buffer FIFO, DEPTH entries; write-to-read latency 1 cycle (0 when FALL_THROUGH and empty).
// Backpressure: w_ready = !full && !flush, registered-only, so a read never frees a slot in the same cycle.
module skid_fifo #(
  parameter int unsigned DATA_WIDTH   = 1,
  parameter type         TYPE         = logic [DATA_WIDTH-1:0],
  parameter int unsigned DEPTH        = 2,
  parameter bit          FALL_THROUGH = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  TYPE                          w_data,
  output logic                         r_valid,
  input  logic                         r_ready,
  output TYPE                          r_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  TYPE              mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             w_fire;
  logic             r_fire;
  logic             bypass;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign w_ready = !full && !flush;

  always_comb begin
    r_valid = !empty && !flush;
    r_data  = mem[rd_ptr];
    bypass  = 1'b0;
    if (FALL_THROUGH) begin
      r_valid = (!empty || w_valid) && !flush;
      if (empty) begin
        r_data = w_data;
      end
      // Word consumed straight from w_data: storage and pointers untouched.
      bypass = empty && w_valid && r_ready && !flush;
    end
  end

  assign w_fire = w_valid && w_ready;
  assign r_fire = r_valid && r_ready;
  assign push   = w_fire && !bypass;
  assign pop    = r_fire && !bypass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= w_data;
    end
  end

endmodule

// File: tb/tb_skid_fifo.sv
// Random and directed stimulus on several skid_fifo configurations, checked against an in-order word-log model.
module tb_skid_fifo;

  localparam int N = 5;
  localparam int DEP [N] = '{3, 2, 1, 4, 3};
  localparam bit FTV [N] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] flush;
  logic [N-1:0] w_valid;
  logic [N-1:0] r_ready;
  logic [N-1:0] w_ready;
  logic [N-1:0] r_valid;
  logic [N-1:0] full;
  logic [N-1:0] empty;
  logic [7:0]   w_data [N];
  logic [7:0]   r_data [N];
  int           cnt    [N];

  int           checks;
  int           failures;
  int           wr_n [N];
  int           rd_n [N];
  logic [7:0]   acc  [N][256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int CW = $clog2(DEP[g] + 1);
    logic [CW-1:0] c;
    logic [7:0]    rd;
    logic          wr;
    logic          rv;
    logic          fu;
    logic          em;

    skid_fifo #(
      .DATA_WIDTH  (8),
      .DEPTH       (DEP[g]),
      .FALL_THROUGH(FTV[g])
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush[g]),
      .w_valid(w_valid[g]),
      .w_ready(wr),
      .w_data (w_data[g]),
      .r_valid(rv),
      .r_ready(r_ready[g]),
      .r_data (rd),
      .count  (c),
      .full   (fu),
      .empty  (em)
    );

    assign w_ready[g] = wr;
    assign r_valid[g] = rv;
    assign full[g]    = fu;
    assign empty[g]   = em;
    assign r_data[g]  = rd;
    assign cnt[g]     = int'(c);
  end

  task automatic chk(input string tag, input integer act, input integer exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic idle();
    w_valid = '0;
    r_ready = '0;
    flush   = '0;
  endtask

  // Expected outputs follow from how many accepted words are still unread.
  task automatic model_check();
    for (int g = 0; g < N; g++) begin
      int n;
      bit ev;
      n  = wr_n[g] - rd_n[g];
      ev = !flush[g] && (n > 0 || (FTV[g] && w_valid[g]));
      chk($sformatf("u%0d_count", g), cnt[g], n);
      chk($sformatf("u%0d_full", g), full[g], (n == DEP[g]) ? 1 : 0);
      chk($sformatf("u%0d_empty", g), empty[g], (n == 0) ? 1 : 0);
      chk($sformatf("u%0d_w_ready", g), w_ready[g], (n < DEP[g] && !flush[g]) ? 1 : 0);
      chk($sformatf("u%0d_r_valid", g), r_valid[g], ev ? 1 : 0);
      if (ev) begin
        chk($sformatf("u%0d_r_data", g), r_data[g],
            (n > 0) ? int'(acc[g][rd_n[g] % 256]) : int'(w_data[g]));
      end
    end
  endtask

  task automatic model_update();
    for (int g = 0; g < N; g++) begin
      int n;
      bit ev;
      bit wr;
      bit rd;
      n  = wr_n[g] - rd_n[g];
      ev = !flush[g] && (n > 0 || (FTV[g] && w_valid[g]));
      if (flush[g]) begin
        rd_n[g] = wr_n[g];
      end else begin
        wr = w_valid[g] && (n < DEP[g]);
        rd = ev && r_ready[g];
        if (wr) begin
          acc[g][wr_n[g] % 256] = w_data[g];
          wr_n[g]++;
        end
        if (rd) begin
          rd_n[g]++;
        end
      end
    end
  endtask

  task automatic cycle();
    #1;
    model_check();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    for (int g = 0; g < N; g++) begin
      w_data[g] = '0;
      wr_n[g]   = 0;
      rd_n[g]   = 0;
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    model_check();
    rst = 1'b0;
    @(negedge clk);

    // Randomized traffic on every configuration.
    repeat (1500) begin
      for (int g = 0; g < N; g++) begin
        w_valid[g] = ($urandom_range(0, 9) < 6);
        r_ready[g] = ($urandom_range(0, 1) == 1);
        flush[g]   = ($urandom_range(0, 19) == 0);
        w_data[g]  = 8'($urandom);
      end
      cycle();
    end
    idle();
    r_ready = '1;
    repeat (5) cycle();
    idle();
    cycle();

    // DEPTH=3: fill, observe full, then drain in order.
    for (int i = 0; i < 3; i++) begin
      w_valid[0] = 1'b1;
      w_data[0]  = 8'(8'hA + i);
      cycle();
    end
    idle();
    #1;
    chk("d3_full", full[0], 1);
    chk("d3_w_ready", w_ready[0], 0);
    chk("d3_count", cnt[0], 3);
    r_ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("d3_rd_valid", r_valid[0], 1);
      chk("d3_rd_data", r_data[0], 'hA + i);
      cycle();
    end
    idle();
    #1;
    chk("d3_empty", empty[0], 1);
    cycle();

    // DEPTH=2: streaming 0..9 with one cycle of latency.
    for (int i = 0; i <= 10; i++) begin
      w_valid[1] = (i < 10);
      w_data[1]  = 8'(i);
      r_ready[1] = 1'b1;
      #1;
      if (i >= 1) begin
        chk("d2_stream_valid", r_valid[1], 1);
        chk("d2_stream_data", r_data[1], i - 1);
      end
      chk("d2_count_le1", (cnt[1] <= 1) ? 1 : 0, 1);
      cycle();
    end
    idle();
    cycle();

    // DEPTH=1 fall-through: bypass when read ready, store when not.
    w_valid[2] = 1'b1;
    w_data[2]  = 8'h5;
    r_ready[2] = 1'b1;
    #1;
    chk("ft_bypass_valid", r_valid[2], 1);
    chk("ft_bypass_data", r_data[2], 5);
    chk("ft_bypass_count", cnt[2], 0);
    cycle();
    #1;
    chk("ft_after_bypass_count", cnt[2], 0);
    w_data[2]  = 8'h6;
    r_ready[2] = 1'b0;
    cycle();
    #1;
    chk("ft_stored_count", cnt[2], 1);
    w_valid[2] = 1'b0;
    r_ready[2] = 1'b1;
    #1;
    chk("ft_stored_data", r_data[2], 6);
    cycle();
    idle();
    cycle();

    // DEPTH=4 full: simultaneous read and write, write refused.
    for (int i = 0; i < 4; i++) begin
      w_valid[3] = 1'b1;
      w_data[3]  = 8'(8'h20 + i);
      cycle();
    end
    w_data[3]  = 8'h30;
    r_ready[3] = 1'b1;
    #1;
    chk("d4_full_w_ready", w_ready[3], 0);
    chk("d4_full_r_valid", r_valid[3], 1);
    chk("d4_full_r_data", r_data[3], 'h20);
    cycle();
    idle();
    #1;
    chk("d4_count_after", cnt[3], 3);
    r_ready[3] = 1'b1;
    repeat (3) cycle();
    idle();
    cycle();

    // Flush at count=2 with a write offered: that word must never appear.
    for (int i = 0; i < 2; i++) begin
      w_valid[0] = 1'b1;
      w_data[0]  = 8'(8'h41 + i);
      cycle();
    end
    flush[0]   = 1'b1;
    w_data[0]  = 8'h99;
    r_ready[0] = 1'b1;
    #1;
    chk("flush_w_ready", w_ready[0], 0);
    chk("flush_r_valid", r_valid[0], 0);
    cycle();
    idle();
    #1;
    chk("flush_count", cnt[0], 0);
    chk("flush_empty", empty[0], 1);
    w_valid[0] = 1'b1;
    w_data[0]  = 8'h11;
    cycle();
    w_valid[0] = 1'b0;
    r_ready[0] = 1'b1;
    #1;
    chk("flush_next_data", r_data[0], 'h11);
    cycle();
    idle();
    cycle();

    // Asynchronous reset mid-stream at count=2.
    for (int i = 0; i < 2; i++) begin
      w_valid[0] = 1'b1;
      w_data[0]  = 8'(8'h51 + i);
      cycle();
    end
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_count", cnt[0], 0);
    chk("rst_r_valid", r_valid[0], 0);
    for (int g = 0; g < N; g++) begin
      rd_n[g] = wr_n[g];
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    w_valid[0] = 1'b1;
    w_data[0]  = 8'h7;
    cycle();
    w_valid[0] = 1'b0;
    r_ready[0] = 1'b1;
    #1;
    chk("rst_first_data", r_data[0], 7);
    cycle();
    idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
